// File: rtl/sha_block_scheduler.sv
// sha_block_scheduler: runs one message hash. It starts the preprocessor, captures the padded blocks and feeds them to the SHA-256 core.
// Defining SCHED_WATCHDOG_EN adds a wait-state watchdog that aborts with an err pulse.
module sha_block_scheduler #(
  parameter int unsigned BLOCK_W    = 512,
  parameter int unsigned MAX_BLOCKS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned WD_CYCLES  = 1024
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 start,
  output logic                                 begin_preprocess,
  input  logic                                 pre_done,
  input  logic [MAX_BLOCKS-1:0][BLOCK_W-1:0]   processed_msg,
  input  logic [IDX_W-1:0]                     position,
  output logic                                 core_start,
  output logic                                 core_first,
  output logic [BLOCK_W-1:0]                   core_block,
  input  logic                                 core_done,
  output logic                                 busy,
  output logic [IDX_W-1:0]                     block_idx,
  output logic                                 hash_done,
  output logic                                 err
);

  if (MAX_BLOCKS != (1 << IDX_W) || WD_CYCLES == 0) begin : g_param_check
    $error("sha_block_scheduler: IDX_W must be clog2(MAX_BLOCKS) and WD_CYCLES nonzero");
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, PREP_REQ, PREP_WAIT, ISSUE, WAIT, DONE, ABORT} state_t;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  assign wd_expired = (wd_cnt == WD_W'(WD_CYCLES - 1));
`else
  typedef enum logic [2:0] {IDLE, PREP_REQ, PREP_WAIT, ISSUE, WAIT, DONE} state_t;
  assign err = 1'b0;
`endif

  state_t                             state;
  logic [MAX_BLOCKS-1:0][BLOCK_W-1:0] buffer;
  logic [IDX_W-1:0]                   last_idx;
  logic [IDX_W-1:0]                   next_idx;
  logic [IDX_W-1:0]                   next_slot;

  // Blocks are issued from the highest populated slot down to slot 0.
  assign next_idx  = block_idx + IDX_W'(1);
  assign next_slot = last_idx - next_idx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      buffer           <= '0;
      last_idx         <= '0;
      block_idx        <= '0;
      core_block       <= '0;
      begin_preprocess <= 1'b0;
      core_start       <= 1'b0;
      core_first       <= 1'b0;
      hash_done        <= 1'b0;
      busy             <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wd_cnt           <= '0;
      err              <= 1'b0;
`endif
    end else begin
      begin_preprocess <= 1'b0;
      core_start       <= 1'b0;
      core_first       <= 1'b0;
      hash_done        <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      err              <= 1'b0;
`endif
      case (state)
        IDLE: begin
          block_idx <= '0;
          if (start) begin
            state            <= PREP_REQ;
            begin_preprocess <= 1'b1;
            busy             <= 1'b1;
          end
        end
        PREP_REQ: begin
          state <= PREP_WAIT;
`ifdef SCHED_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        PREP_WAIT: begin
          if (pre_done) begin
            buffer     <= processed_msg;
            last_idx   <= position;
            core_block <= processed_msg[position];
            core_start <= 1'b1;
            core_first <= 1'b1;
            state      <= ISSUE;
          end
`ifdef SCHED_WATCHDOG_EN
          else if (wd_expired) begin
            state <= ABORT;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SCHED_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            if (block_idx == last_idx) begin
              state     <= DONE;
              hash_done <= 1'b1;
            end else begin
              block_idx  <= next_idx;
              core_block <= buffer[next_slot];
              core_start <= 1'b1;
              state      <= ISSUE;
            end
          end
`ifdef SCHED_WATCHDOG_EN
          else if (wd_expired) begin
            state <= ABORT;
            err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef SCHED_WATCHDOG_EN
        ABORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_block_scheduler.sv
// Bench for sha_block_scheduler: randomized hashes checked each cycle against a queue-based transaction model.
module tb_sha_block_scheduler;
  localparam int unsigned BW = 512;
  localparam int unsigned NB = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned WD = 16;

  logic                   clk = 1'b0;
  logic                   n_rst = 1'b0;
  logic                   start = 1'b0;
  logic                   pre_done = 1'b0;
  logic                   core_done = 1'b0;
  logic [NB-1:0][BW-1:0]  processed_msg = '0;
  logic [IW-1:0]          position = '0;
  logic                   begin_preprocess, core_start, core_first, busy, hash_done, err;
  logic [BW-1:0]          core_block;
  logic [IW-1:0]          block_idx;

  sha_block_scheduler #(.BLOCK_W(BW), .MAX_BLOCKS(NB), .IDX_W(IW), .WD_CYCLES(WD)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .begin_preprocess(begin_preprocess),
    .pre_done(pre_done), .processed_msg(processed_msg), .position(position),
    .core_start(core_start), .core_first(core_first), .core_block(core_block),
    .core_done(core_done), .busy(busy), .block_idx(block_idx),
    .hash_done(hash_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int bp_cnt = 0;
  int cs_cnt = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a hash is a request, a preprocessor wait, then a queue of blocks drained one per core handshake.
  bit             m_busy, m_bp, m_cs, m_first, m_hd, m_err, m_wpre, m_wcore;
  bit             n_busy, n_bp, n_cs, n_first, n_hd, n_err;
  int             m_idx, m_wcnt;
  logic [BW-1:0]  m_block;
  logic [BW-1:0]  m_q[$];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      {m_busy, m_bp, m_cs, m_first, m_hd, m_err, m_wpre, m_wcore} = '0;
      m_idx = 0; m_wcnt = 0; m_block = '0; m_q.delete();
    end else begin
      {n_bp, n_cs, n_first, n_hd, n_err} = '0;
      n_busy = m_busy;
      if (!m_busy && start) begin n_bp = 1; n_busy = 1; end
      if (m_wpre) begin
        if (pre_done) begin
          m_q.delete();
          for (int k = int'(position); k >= 0; k--) m_q.push_back(processed_msg[k]);
          m_block = m_q.pop_front();
          m_idx = 0; n_cs = 1; n_first = 1; m_wpre = 0;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (m_wcnt == WD - 1) begin n_err = 1; m_wpre = 0; end
`endif
        else m_wcnt++;
      end else if (m_wcore) begin
        if (core_done) begin
          m_wcore = 0;
          if (m_q.size() == 0) n_hd = 1;
          else begin m_block = m_q.pop_front(); m_idx++; n_cs = 1; end
        end
`ifdef SCHED_WATCHDOG_EN
        else if (m_wcnt == WD - 1) begin n_err = 1; m_wcore = 0; m_q.delete(); end
`endif
        else m_wcnt++;
      end
      if (m_bp) begin m_wpre = 1; m_wcnt = 0; end
      if (m_cs) begin m_wcore = 1; m_wcnt = 0; end
      if (m_hd || m_err) n_busy = 0;
      m_busy = n_busy; m_bp = n_bp; m_cs = n_cs; m_first = n_first; m_hd = n_hd; m_err = n_err;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("begin_preprocess", begin_preprocess, m_bp);
    check("core_start", core_start, m_cs);
    check("hash_done", hash_done, m_hd);
    check("err", err, m_err);
    check("core_block", core_block, m_block);
    if (m_cs) begin
      check("core_first", core_first, m_first);
      check("block_idx", block_idx, m_idx);
    end
    if (begin_preprocess) bp_cnt++;
    if (core_start) cs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_msg(output logic [NB-1:0][BW-1:0] m);
    for (int s = 0; s < int'(NB); s++)
      for (int w = 0; w < int'(BW / 32); w++) m[s][w*32 +: 32] = $urandom;
  endtask

  task automatic run_hash(input logic [NB-1:0][BW-1:0] msg, input int npos, input int pre_lat,
                          input int core_lat, input bit noise, input bit rst_at1);
    int bp0, cs0, t;
    logic [NB-1:0][BW-1:0] junk;
    bp0 = bp_cnt; cs0 = cs_cnt;
    start = 1'b1;
    tick();
    if (!noise) start = 1'b0;
    check("start_to_begin_preprocess", begin_preprocess, 1'b1);
    t = 0;
    while (!begin_preprocess && t < 8) begin tick(); t++; end
    if (!begin_preprocess) begin check("begin_preprocess_timeout", 1'b0, 1'b1); start = 1'b0; return; end
    for (int i = 1; i <= pre_lat; i++) begin
      tick();
      core_done = noise && (i == 1) && (i != pre_lat);
      if (i == pre_lat) begin pre_done = 1'b1; processed_msg = msg; position = IW'(npos); end
    end
    tick();
    pre_done = 1'b0; core_done = 1'b0;
    if (noise) begin core_done = 1'b1; position = 2'd3; rand_msg(junk); processed_msg = junk; end
    for (int k = 0; k <= npos; k++) begin
      check("core_start_latency", core_start, 1'b1);
      t = 0;
      while (!core_start && t < 8) begin tick(); core_done = 1'b0; t++; end
      if (!core_start) begin check("core_start_timeout", 1'b0, 1'b1); start = 1'b0; return; end
      check("issued_block", core_block, msg[npos-k]);
      check("issued_first", core_first, k == 0);
      check("issued_idx", block_idx, k);
      if (rst_at1 && k == 1) begin
        tick();
        n_rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_hash_done", hash_done, 1'b0);
        tick();
        n_rst = 1'b1;
        tick();
        return;
      end
      for (int j = 1; j <= core_lat; j++) begin tick(); core_done = (j == core_lat); end
      tick();
      core_done = 1'b0;
    end
    check("hash_done_latency", hash_done, 1'b1);
    start = 1'b0;
    tick(); tick();
    check("begin_preprocess_count", bp_cnt - bp0, 1);
    check("core_start_count", cs_cnt - cs0, npos + 1);
  endtask

`ifdef SCHED_WATCHDOG_EN
  task automatic wd_test();
    logic [NB-1:0][BW-1:0] m;
    rand_msg(m);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    pre_done = 1'b1; processed_msg = m; position = '0;
    tick(); pre_done = 1'b0;
    tick();
    repeat (WD - 1) tick();
    check("wd_err_early", err, 1'b0);
    tick();
    check("wd_err_pulse", err, 1'b1);
    tick();
    check("wd_idle_after_abort", busy, 1'b0);
    check("wd_no_hash_done", hash_done, 1'b0);
  endtask
`endif

  initial begin
    logic [NB-1:0][BW-1:0] m;
    n_rst = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_core_block", core_block, '0);
    check("reset_block_idx", block_idx, '0);
    check("reset_err", err, 1'b0);
    n_rst = 1'b1;
    tick();

    rand_msg(m);
    run_hash(m, 0, 3, 2, 1'b0, 1'b0);

    m[3] = {128{4'hA}}; m[2] = {128{4'hB}}; m[1] = {128{4'hC}}; m[0] = {128{4'hD}};
    run_hash(m, 3, 2, 1, 1'b0, 1'b0);

    rand_msg(m);
    run_hash(m, 1, 3, 2, 1'b1, 1'b0);

    rand_msg(m);
    run_hash(m, 2, 2, 2, 1'b0, 1'b1);
    rand_msg(m);
    run_hash(m, 2, 1, 1, 1'b0, 1'b0);

`ifdef SCHED_WATCHDOG_EN
    wd_test();
`else
    rand_msg(m);
    run_hash(m, 0, 2, 40, 1'b0, 1'b0);
`endif

    for (int r = 0; r < 30; r++) begin
      rand_msg(m);
      run_hash(m, int'($urandom_range(3, 0)), int'($urandom_range(5, 1)),
               int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
